// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and SPI idle levels for the port arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  localparam logic SS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int CNT_W = 8;

endpackage

// File: rtl/spi_arb_sync.sv
// rtl/spi_arb_sync.sv - N-bit multi-stage synchroniser with a per-bit reset level
module spi_arb_sync #(
  parameter int             W      = 1,
  parameter int             STAGES = 2,
  parameter logic [W-1:0]   INIT   = '0
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= INIT;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_port_arbiter.sv
// rtl/spi_port_arbiter.sv - arbitrates several SPI initiators onto one shared target
module spi_port_arbiter #(
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYC    = 4,
  parameter int RR_MODE     = 0
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [NCH-1:0]         ss_n,
  input  logic [NCH-1:0]         sck_in,
  input  logic [NCH-1:0]         mosi_in,
  output logic                   sck_out,
  output logic                   mosi_out,
  output logic                   ss_out_n,
  input  logic                   miso_in,
  output logic [NCH-1:0]         miso_oe,
  output logic [$clog2(NCH)-1:0] owner,
  output logic                   owner_valid,
  output logic                   collision
);
  import spi_arb_pkg::*;

  localparam int OW = $clog2(NCH);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IDLE_CYC - 1);

  arb_state_t       state;
  logic [NCH-1:0]   ss_s, sck_s, mosi_s, ss_prev, own_mask, ss_fall;
  logic             own_ss, own_sck, own_mosi, req_any, found;
  logic [OW-1:0]    win, rr_ptr, cand;
  logic [CNT_W-1:0] drain_cnt;
  int               idx;
  logic             unused_miso;

  // The return line is steered by the board-level tri-states via miso_oe.
  assign unused_miso = miso_in;

  spi_arb_sync #(.W(NCH), .STAGES(SYNC_STAGES), .INIT({NCH{SS_IDLE}})) u_sync_ss (
    .clk_sys(clk_sys), .reset(reset), .d(ss_n), .q(ss_s)
  );
  spi_arb_sync #(.W(NCH), .STAGES(SYNC_STAGES), .INIT({NCH{SCK_IDLE}})) u_sync_sck (
    .clk_sys(clk_sys), .reset(reset), .d(sck_in), .q(sck_s)
  );
  spi_arb_sync #(.W(NCH), .STAGES(SYNC_STAGES), .INIT({NCH{MOSI_IDLE}})) u_sync_mosi (
    .clk_sys(clk_sys), .reset(reset), .d(mosi_in), .q(mosi_s)
  );

  // Search starts at 0 for fixed priority, or just after the last owner for round-robin.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = (RR_MODE != 0) ? int'(rr_ptr) + 1 + i : i;
      if (idx >= NCH) idx = idx - NCH;
      cand = OW'(idx);
      if (!found && !ss_s[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
  end

  assign own_ss   = ss_s[owner];
  assign own_sck  = sck_s[owner];
  assign own_mosi = mosi_s[owner];
  assign ss_fall  = ss_prev & ~ss_s;
  assign req_any  = ~&ss_s;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      owner_valid <= 1'b0;
      ss_out_n    <= SS_IDLE;
      sck_out     <= SCK_IDLE;
      mosi_out    <= MOSI_IDLE;
      miso_oe     <= '0;
      collision   <= 1'b0;
      rr_ptr      <= OW'(NCH - 1);
      drain_cnt   <= '0;
      ss_prev     <= {NCH{SS_IDLE}};
    end else begin
      ss_prev   <= ss_s;
      collision <= (state != IDLE) && (|(ss_fall & ~own_mask));

      // Outside IDLE the bus mirrors the owner one cycle behind the synchronisers.
      if (state != IDLE) begin
        ss_out_n <= own_ss;
        sck_out  <= own_sck;
        mosi_out <= own_mosi;
      end

      case (state)
        IDLE: begin
          if (req_any) begin
            owner       <= win;
            rr_ptr      <= win;
            owner_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          miso_oe <= own_mask;
          state   <= ACTIVE;
        end
        ACTIVE: begin
          if (own_ss) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!own_ss) begin
            state <= ACTIVE;
          end else if (own_sck) begin
            drain_cnt <= '0;
          end else if (drain_cnt >= DRAIN_LAST) begin
            owner_valid <= 1'b0;
            miso_oe     <= '0;
            ss_out_n    <= SS_IDLE;
            sck_out     <= SCK_IDLE;
            mosi_out    <= MOSI_IDLE;
            state       <= IDLE;
          end else if (drain_cnt != '1) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_port_arbiter.sv
// tb/tb_spi_port_arbiter.sv - self-checking bench for spi_port_arbiter
module tb_spi_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] ss_a, sck_a, mosi_a, ss_b, sck_b, mosi_b;
  logic       miso;

  logic       sck_out_a, mosi_out_a, ss_out_n_a, owner_valid_a, collision_a;
  logic [3:0] miso_oe_a;
  logic [1:0] owner_a;
  logic       sck_out_b, mosi_out_b, ss_out_n_b, owner_valid_b, collision_b;
  logic [3:0] miso_oe_b;
  logic [1:0] owner_b;
  logic       sck_out_c, mosi_out_c, ss_out_n_c, owner_valid_c, collision_c;
  logic [1:0] miso_oe_c;
  logic [0:0] owner_c;

  spi_port_arbiter #(.NCH(4), .SYNC_STAGES(2), .IDLE_CYC(4), .RR_MODE(0)) dut_a (
    .clk_sys(clk), .reset(reset), .ss_n(ss_a), .sck_in(sck_a), .mosi_in(mosi_a),
    .sck_out(sck_out_a), .mosi_out(mosi_out_a), .ss_out_n(ss_out_n_a), .miso_in(miso),
    .miso_oe(miso_oe_a), .owner(owner_a), .owner_valid(owner_valid_a), .collision(collision_a)
  );

  spi_port_arbiter #(.NCH(4), .SYNC_STAGES(2), .IDLE_CYC(4), .RR_MODE(1)) dut_b (
    .clk_sys(clk), .reset(reset), .ss_n(ss_b), .sck_in(sck_b), .mosi_in(mosi_b),
    .sck_out(sck_out_b), .mosi_out(mosi_out_b), .ss_out_n(ss_out_n_b), .miso_in(miso),
    .miso_oe(miso_oe_b), .owner(owner_b), .owner_valid(owner_valid_b), .collision(collision_b)
  );

  spi_port_arbiter #(.NCH(2), .SYNC_STAGES(2), .IDLE_CYC(4), .RR_MODE(0)) dut_c (
    .clk_sys(clk), .reset(reset), .ss_n(ss_a[1:0]), .sck_in(sck_a[1:0]), .mosi_in(mosi_a[1:0]),
    .sck_out(sck_out_c), .mosi_out(mosi_out_c), .ss_out_n(ss_out_n_c), .miso_in(miso),
    .miso_oe(miso_oe_c), .owner(owner_c), .owner_valid(owner_valid_c), .collision(collision_c)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int coll_a   = 0;
  int coll_b   = 0;

  always @(negedge clk) begin
    if (collision_a) coll_a++;
    if (collision_b) coll_b++;
  end

  typedef struct {
    logic [3:0] req;
    int         exp_owner;
  } arb_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic valid_of(input int which);
    return (which == 0) ? owner_valid_a : owner_valid_b;
  endfunction

  task automatic wait_valid(input int which, input logic want, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i <= budget; i++) begin
      if (valid_of(which) == want) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("wait_owner_valid", ok, 1);
  endtask

  arb_vec_t   vecs[6];
  bit         sq[$], mq[$], ssq[$];
  int         c0, ok, drop, last, exp_o, j;
  logic [1:0] li;
  logic [3:0] m;

  initial begin
    vecs[0] = '{4'b0101, 0};
    vecs[1] = '{4'b1000, 3};
    vecs[2] = '{4'b1100, 2};
    vecs[3] = '{4'b0110, 1};
    vecs[4] = '{4'b1111, 0};
    vecs[5] = '{4'b0010, 1};

    reset = 1'b1;
    ss_a = '1; sck_a = '0; mosi_a = '0;
    ss_b = '1; sck_b = '0; mosi_b = '0;
    miso = 1'b0;
    repeat (3) tick();
    check("rst_owner_valid", int'(owner_valid_a), 0);
    check("rst_owner", int'(owner_a), 0);
    check("rst_ss_out_n", int'(ss_out_n_a), 1);
    check("rst_sck_out", int'(sck_out_a), 0);
    check("rst_mosi_out", int'(mosi_out_a), 0);
    check("rst_miso_oe", int'(miso_oe_a), 0);
    check("rst_collision", int'(collision_a), 0);
    check("rst_b_owner_valid", int'(owner_valid_b), 0);
    check("rst_c_ss_out_n", int'(ss_out_n_c), 1);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_owner_valid", int'(owner_valid_a), 0);

    // Single transfer on channel 1: outputs are a 3-cycle delay line of the inputs.
    c0 = coll_a;
    ss_a[1] = 1'b0;
    for (int it = 1; it <= 28; it++) begin
      if (it >= 5 && it <= 20) begin
        sck_a[1]  = ~sck_a[1];
        mosi_a[1] = 1'($urandom_range(0, 1));
      end else begin
        sck_a[1]  = 1'b0;
        mosi_a[1] = 1'b0;
      end
      if (it == 21) ss_a[1] = 1'b1;
      sq.push_back(sck_a[1]);
      mq.push_back(mosi_a[1]);
      ssq.push_back(ss_a[1]);
      tick();
      if (it == 3) begin
        check("grant_valid", int'(owner_valid_c), 1);
        check("grant_owner", int'(owner_c), 1);
        check("grant_ss_out_n", int'(ss_out_n_c), 1);
      end
      if (it == 4) check("active_miso_oe", int'(miso_oe_c), 2);
      if (it >= 4 && it <= 26) begin
        check("pass_ss_out_n", int'(ss_out_n_c), int'(ssq[ssq.size()-3]));
        check("pass_sck_out", int'(sck_out_c), int'(sq[sq.size()-3]));
        check("pass_mosi_out", int'(mosi_out_c), int'(mq[mq.size()-3]));
        check("pass_owner_valid", int'(owner_valid_c), 1);
      end
      if (it == 10) check("seq_a_owner", int'(owner_a), 1);
      if (it == 27) begin
        check("drain_done_valid", int'(owner_valid_c), 0);
        check("drain_done_miso_oe", int'(miso_oe_c), 0);
        check("drain_done_ss_out_n", int'(ss_out_n_c), 1);
      end
    end
    check("seq_no_collision", coll_a - c0, 0);
    repeat (4) tick();

    // Fixed-priority arbitration table, all requests applied on the same cycle.
    for (int v = 0; v < 6; v++) begin
      c0 = coll_a;
      ss_a = ~vecs[v].req;
      repeat (4) tick();
      check("vec_owner", int'(owner_a), vecs[v].exp_owner);
      check("vec_valid", int'(owner_valid_a), 1);
      check("vec_ss_out_n", int'(ss_out_n_a), 0);
      check("vec_miso_oe", int'(miso_oe_a), 1 << vecs[v].exp_owner);
      repeat (4) tick();
      check("vec_collision", coll_a - c0, 0);
      ss_a = '1;
      wait_valid(0, 1'b0, 20);
      repeat (4) tick();
    end

    // Late request from channel 1 while channel 0 owns the bus.
    c0 = coll_a;
    ss_a = 4'b1110;
    repeat (6) tick();
    ss_a[1] = 1'b0;
    repeat (8) tick();
    check("coll_once", coll_a - c0, 1);
    check("coll_owner_kept", int'(owner_a), 0);
    ss_a[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (owner_valid_a && owner_a == 2'd1) begin
        ok = 1;
        break;
      end
    end
    check("coll_handover", ok, 1);
    check("coll_no_repeat", coll_a - c0, 1);
    ss_a = '1;
    wait_valid(0, 1'b0, 20);
    repeat (4) tick();

    // Owner re-selects two cycles into the drain window.
    ss_a = 4'b1110;
    repeat (8) tick();
    ss_a[0] = 1'b1;
    drop = 0;
    for (int it = 1; it <= 12; it++) begin
      if (it == 4) ss_a[0] = 1'b0;
      tick();
      if (!owner_valid_a) drop = 1;
      if (it == 3 || it == 5) check("drain_ss_out_high", int'(ss_out_n_a), 1);
      if (it == 6 || it == 12) check("drain_ss_out_back", int'(ss_out_n_a), 0);
    end
    check("drain_kept_grant", drop, 0);
    check("drain_owner", int'(owner_a), 0);

    // Reset in the middle of a transfer; grant returns once synchronisers refill.
    reset = 1'b1;
    tick();
    check("mid_rst_ss_out_n", int'(ss_out_n_a), 1);
    check("mid_rst_miso_oe", int'(miso_oe_a), 0);
    check("mid_rst_valid", int'(owner_valid_a), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("refill_valid_low", int'(owner_valid_a), 0);
    tick();
    check("refill_valid_high", int'(owner_valid_a), 1);
    check("refill_owner", int'(owner_a), 0);
    ss_a = '1;
    wait_valid(0, 1'b0, 20);
    repeat (4) tick();

    // Round-robin: all four held, owner released in turn; pointer starts at NCH-1.
    ss_b = 4'b0000;
    wait_valid(1, 1'b1, 20);
    check("rr_first", int'(owner_b), 0);
    last = 0;
    for (int k = 0; k < 4; k++) begin
      exp_o = (last + 1) % 4;
      li = 2'(last);
      ss_b[li] = 1'b1;
      wait_valid(1, 1'b0, 30);
      ss_b[li] = 1'b0;
      wait_valid(1, 1'b1, 30);
      check("rr_order", int'(owner_b), exp_o);
      last = exp_o;
    end
    ss_b = '1;
    wait_valid(1, 1'b0, 30);
    repeat (4) tick();

    // Random request sets against the "first requester after last owner" rule.
    for (int r = 0; r < 12; r++) begin
      m = 4'($urandom_range(1, 15));
      exp_o = -1;
      for (int i = 1; i <= 4; i++) begin
        j = (last + i) % 4;
        if (((int'(m) >> j) & 1) == 1) begin
          exp_o = j;
          break;
        end
      end
      ss_b = ~m;
      wait_valid(1, 1'b1, 20);
      check("rr_rand_owner", int'(owner_b), exp_o);
      last = exp_o;
      ss_b = '1;
      wait_valid(1, 1'b0, 30);
      repeat (3) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
